// File: rtl/mul_ctrl_pkg.sv
// Shared types and digit widths for the sequential digit-serial multiplier.
//   state_e  : sequencer states
//   A_DIG_W  : multiplicand digit width
//   B_DIG_W  : multiplier digit width
//   PP_W     : digit partial-product width
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned A_DIG_W = 2;
  localparam int unsigned B_DIG_W = 3;
  localparam int unsigned PP_W    = A_DIG_W + B_DIG_W;

  // Counter width for n values; a single-value counter still needs one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_mult_2_3.sv
// Mult_2_3: combinational 2-bit x 3-bit unsigned multiplier, 5-bit product.
//   a_i    : 2-bit digit
//   b_i    : 3-bit digit
//   prod_c : a_i * b_i (combinational)
module Mult_2_3
  import mul_ctrl_pkg::*;
(
  input  logic [A_DIG_W-1:0] a_i,
  input  logic [B_DIG_W-1:0] b_i,
  output logic [PP_W-1:0]    prod_c
);

  assign prod_c = PP_W'(a_i) * PP_W'(b_i);

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: builds an A_W x B_W unsigned product by stepping one
// Mult_2_3 over every (A digit, B digit) pair and accumulating the shifted
// partial products.
//   clk, rst             : clock, async active-high reset
//   in_valid/in_ready    : operand handshake, in_a / in_b operands
//   abort                : synchronous cancel of the operation in flight
//   busy                 : sequencer not idle
//   out_valid/out_ready  : result handshake, out_prod result
module mul_seq_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned A_W = 8,
  parameter int unsigned B_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [A_W+B_W-1:0] out_prod
);

  localparam int unsigned P_W  = A_W + B_W;
  localparam int unsigned ND_A = A_W / A_DIG_W;
  localparam int unsigned ND_B = B_W / B_DIG_W;
  localparam int unsigned I_W  = cnt_w(ND_A);
  localparam int unsigned J_W  = cnt_w(ND_B);
  localparam int unsigned SH_W = $clog2(P_W) + 1;

  // Operand widths must split into whole digits.
  generate
    if ((A_W == 0) || ((A_W % A_DIG_W) != 0)) begin : g_bad_a_w
      $error("mul_seq_ctrl: A_W must be a non-zero multiple of 2");
    end
    if ((B_W == 0) || ((B_W % B_DIG_W) != 0)) begin : g_bad_b_w
      $error("mul_seq_ctrl: B_W must be a non-zero multiple of 3");
    end
  endgenerate

  state_e           state_q,     state_d;
  logic [A_W-1:0]   a_q,         a_d;
  logic [B_W-1:0]   b_q,         b_d;
  logic [P_W-1:0]   acc_q,       acc_d;
  logic [I_W-1:0]   i_q,         i_d;
  logic [J_W-1:0]   j_q,         j_d;
  logic             out_valid_q, out_valid_d;
  logic [P_W-1:0]   out_prod_q,  out_prod_d;
  logic             busy_q,      busy_d;
  logic             in_ready_q,  in_ready_d;

  logic [A_DIG_W-1:0] a_dig_c;
  logic [B_DIG_W-1:0] b_dig_c;
  logic [PP_W-1:0]    pp_c;
  logic [SH_W-1:0]    shamt_c;
  logic [P_W-1:0]     pp_sh_c;
  logic [P_W-1:0]     acc_sum_c;
  logic               j_last_c;
  logic               i_last_c;

  // Current digit pair and its weighted partial product.
  assign a_dig_c   = A_DIG_W'(a_q >> (A_DIG_W * i_q));
  assign b_dig_c   = B_DIG_W'(b_q >> (B_DIG_W * j_q));
  assign shamt_c   = SH_W'((A_DIG_W * i_q) + (B_DIG_W * j_q));
  assign pp_sh_c   = P_W'(pp_c) << shamt_c;
  assign acc_sum_c = acc_q + pp_sh_c;
  assign j_last_c  = (j_q == J_W'(ND_B - 1));
  assign i_last_c  = (i_q == I_W'(ND_A - 1));

  Mult_2_3 u_mult (
    .a_i    (a_dig_c),
    .b_i    (b_dig_c),
    .prod_c (pp_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      out_valid_q <= out_valid_d;
      out_prod_q  <= out_prod_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    out_valid_d = out_valid_q;
    out_prod_d  = out_prod_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = IDLE;
        end else begin
          acc_d = acc_sum_c;
          if (j_last_c) begin
            j_d = '0;
            if (i_last_c) begin
              i_d         = '0;
              out_valid_d = 1'b1;
              out_prod_d  = acc_sum_c;
              state_d     = DONE;
            end else begin
              i_d = i_q + I_W'(1);
            end
          end else begin
            j_d = j_q + J_W'(1);
          end
        end
      end
      DONE: begin
        // abort outranks the consumer handshake.
        if (abort) begin
          acc_d       = '0;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Status flags track the state being entered so they are registered.
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: directed scenarios and random traffic on an 8x9
// instance, then random traffic on a 4x6 instance. Expected products come
// from plain a*b and latency from the digit-pair count.
module tb_mul_seq_ctrl;

  localparam int unsigned AW  = 8;
  localparam int unsigned BW  = 9;
  localparam int unsigned SAW = 4;
  localparam int unsigned SBW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          abort;
  logic          out_ready;
  logic          sel;
  logic [AW-1:0] in_a;
  logic [BW-1:0] in_b;

  logic              m_in_ready, m_busy, m_out_valid;
  logic [AW+BW-1:0]  m_out_prod;
  logic              s_in_ready, s_busy, s_out_valid;
  logic [SAW+SBW-1:0] s_out_prod;

  logic        m_in_valid, s_in_valid;
  logic        v_in_ready, v_busy, v_out_valid;
  logic [63:0] v_prod;

  int total = 0;
  int bad   = 0;

  assign m_in_valid  = in_valid & ~sel;
  assign s_in_valid  = in_valid & sel;
  assign v_in_ready  = sel ? s_in_ready  : m_in_ready;
  assign v_busy      = sel ? s_busy      : m_busy;
  assign v_out_valid = sel ? s_out_valid : m_out_valid;
  assign v_prod      = sel ? 64'(s_out_prod) : 64'(m_out_prod);

  mul_seq_ctrl #(.A_W(AW), .B_W(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .abort     (abort),
    .busy      (m_busy),
    .out_valid (m_out_valid),
    .out_ready (out_ready),
    .out_prod  (m_out_prod)
  );

  mul_seq_ctrl #(.A_W(SAW), .B_W(SBW)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_a      (in_a[SAW-1:0]),
    .in_b      (in_b[SBW-1:0]),
    .abort     (abort),
    .busy      (s_busy),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_prod  (s_out_prod)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // One transaction: offer operands, time the result, stall, then drain.
  task automatic run_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input int stall, input bit noise, input bit pulse);
    int          k;
    int          n;
    bit          seen;
    logic [63:0] exp;
    k   = sel ? int'((SAW / 2) * (SBW / 3)) : int'((AW / 2) * (BW / 3));
    exp = sel ? 64'(a[SAW-1:0]) * 64'(b[SBW-1:0]) : 64'(a) * 64'(b);
    check("in_ready_idle", 64'(v_in_ready), 64'd1);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3 * k) begin
      check("busy_calc", 64'(v_busy), 64'd1);
      check("in_ready_calc", 64'(v_in_ready), 64'd0);
      if (noise) begin
        in_valid = 1'($urandom);
        in_a     = AW'($urandom);
        in_b     = BW'($urandom);
      end
      @(negedge clk);
      n++;
      seen = v_out_valid;
    end
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(k));
    if (seen) begin
      check("prod", v_prod, exp);
      for (int s = 0; s < stall; s++) begin
        if (pulse) begin
          in_valid = 1'b1;
          in_a     = AW'($urandom);
          in_b     = BW'($urandom);
        end
        @(negedge clk);
        check("hold_valid", 64'(v_out_valid), 64'd1);
        check("hold_prod", v_prod, exp);
        check("in_ready_done", 64'(v_in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_drop", 64'(v_out_valid), 64'd0);
      check("in_ready_back", 64'(v_in_ready), 64'd1);
      check("busy_back", 64'(v_busy), 64'd0);
      check("prod_kept", v_prod, exp);
    end
  endtask

  initial begin
    sel       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    #1;
    check("rst_out_valid", 64'(v_out_valid), 64'd0);
    check("rst_out_prod", v_prod, 64'd0);
    check("rst_busy", 64'(v_busy), 64'd0);
    check("rst_in_ready", 64'(v_in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full-scale operands.
    run_op(8'd255, 9'd511, 0, 1'b0, 1'b0);
    check("t1_value", v_prod, 64'd130305);

    // Back-to-back, including a zero operand.
    run_op(8'd0, 9'd300, 0, 1'b0, 1'b0);
    run_op(8'd3, 9'd5, 0, 1'b0, 1'b0);
    check("t2_value", v_prod, 64'd15);

    // Consumer stall with an ignored in_valid pulse.
    run_op(8'd200, 9'd100, 5, 1'b0, 1'b1);
    check("t3_value", v_prod, 64'd20000);

    // Abort sampled on the sixth CALC edge.
    in_a     = 8'd77;
    in_b     = 9'd99;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(v_busy), 64'd0);
    check("abort_in_ready", 64'(v_in_ready), 64'd1);
    begin
      int rises = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (v_out_valid) rises++;
      end
      check("abort_no_valid", 64'(rises), 64'd0);
    end
    run_op(8'd7, 9'd9, 0, 1'b0, 1'b0);
    check("t4_value", v_prod, 64'd63);

    // Reset asserted mid-CALC.
    in_a     = 8'd100;
    in_b     = 9'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(v_out_valid), 64'd0);
    check("midrst_out_prod", v_prod, 64'd0);
    check("midrst_busy", 64'(v_busy), 64'd0);
    check("midrst_in_ready", 64'(v_in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd1, 9'd1, 0, 1'b0, 1'b0);
    check("t5_value", v_prod, 64'd1);

    // Random traffic, default widths.
    for (int t = 0; t < 2000; t++) begin
      run_op(AW'($urandom), BW'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom));
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    // Random traffic, 4x6 instance.
    sel = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 1000; t++) begin
      run_op(AW'($urandom), BW'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom));
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
